// File: rtl/state_readout.sv
// state_readout
//   Serialises a snapshot of the latch-chain spin/Potts state into a byte
//   frame: HEADER, seq, NBYTES payload bytes (LSB byte first), checksum.
//   The checksum is the XOR of the seq byte and every payload byte.
//   The state vector is captured when a frame is accepted, so later changes
//   on the input never reach the frame in flight.
//
// Ports
//   clk      : single clock, all logic on its rising edge
//   rst      : asynchronous active-high reset, aborts any frame at once
//   state    : spin/Potts state vector (8*NBYTES bits)
//   start    : single-cycle request to snapshot and send one frame
//   tx_data  : current frame byte (8'h00 while tx_valid is low)
//   tx_valid : tx_data holds a byte waiting for transfer
//   tx_ready : downstream accepts the byte on this edge
//   busy     : a frame is in flight
//   seq      : sequence number carried by the next frame
//   dropped  : saturating count of start requests that were ignored
module state_readout #(
  parameter logic [7:0] HEADER = 8'hA5,
  parameter int         NBYTES = 18
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [8*NBYTES-1:0]   state,
  input  logic                  start,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic [7:0]            seq,
  output logic [15:0]           dropped
);

  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int SW = 8 * NBYTES;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    SEQ  = 3'd2,
    DATA = 3'd3,
    CSUM = 3'd4
  } fsm_t;

  fsm_t            fsm_r;
  logic [SW-1:0]   snap_r;
  logic [IW-1:0]   idx_r;
  logic [7:0]      csum_r;
  logic [7:0]      seq_r;
  logic [15:0]     dropped_r;
  logic [7:0]      tx_data_r;
  logic            tx_valid_r;
  logic            busy_r;

  logic            xfer_s;
  logic            last_s;
  logic [IW-1:0]   next_idx_s;
  logic [7:0]      next_byte_s;
  logic [7:0]      csum_next_s;

  // One step of the running frame checksum.
  function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
    csum_step = acc ^ b;
  endfunction

  // Select payload byte k of the snapshot; out-of-range indices give 8'h00.
  function automatic logic [7:0] pick_byte(input logic [SW-1:0] v, input logic [IW-1:0] k);
    pick_byte = 8'h00;
    for (int i = 0; i < NBYTES; i++) begin
      if (k == IW'(i)) begin
        pick_byte = v[8*i +: 8];
      end else begin
        pick_byte = pick_byte;
      end
    end
  endfunction

  // Transfer qualifier and next-byte look-ahead used by the FSM.
  always_comb begin
    xfer_s      = tx_valid_r & tx_ready;
    last_s      = (idx_r == IW'(NBYTES - 1));
    next_idx_s  = idx_r + IW'(1);
    next_byte_s = pick_byte(snap_r, next_idx_s);
    // In SEQ and DATA the byte being transferred is exactly tx_data_r.
    csum_next_s = csum_step(csum_r, tx_data_r);
  end

  // Frame FSM with registered byte stream, sequence and drop counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_r      <= IDLE;
      snap_r     <= '0;
      idx_r      <= '0;
      csum_r     <= 8'h00;
      seq_r      <= 8'h00;
      dropped_r  <= 16'h0000;
      tx_data_r  <= 8'h00;
      tx_valid_r <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      // A start outside IDLE (including the CSUM transfer edge) is ignored.
      if (start && (fsm_r != IDLE) && (dropped_r != 16'hFFFF)) begin
        dropped_r <= dropped_r + 16'd1;
      end

      case (fsm_r)
        IDLE: begin
          if (start) begin
            snap_r     <= state;
            idx_r      <= '0;
            csum_r     <= 8'h00;
            tx_data_r  <= HEADER;
            tx_valid_r <= 1'b1;
            busy_r     <= 1'b1;
            fsm_r      <= HDR;
          end
        end
        HDR: begin
          if (xfer_s) begin
            tx_data_r <= seq_r;
            fsm_r     <= SEQ;
          end
        end
        SEQ: begin
          if (xfer_s) begin
            csum_r    <= csum_next_s;
            idx_r     <= '0;
            tx_data_r <= pick_byte(snap_r, '0);
            fsm_r     <= DATA;
          end
        end
        DATA: begin
          if (xfer_s) begin
            csum_r <= csum_next_s;
            if (last_s) begin
              tx_data_r <= csum_next_s;
              fsm_r     <= CSUM;
            end else begin
              idx_r     <= next_idx_s;
              tx_data_r <= next_byte_s;
            end
          end
        end
        CSUM: begin
          if (xfer_s) begin
            seq_r      <= seq_r + 8'd1;
            tx_data_r  <= 8'h00;
            tx_valid_r <= 1'b0;
            busy_r     <= 1'b0;
            fsm_r      <= IDLE;
          end
        end
        default: begin
          tx_data_r  <= 8'h00;
          tx_valid_r <= 1'b0;
          busy_r     <= 1'b0;
          fsm_r      <= IDLE;
        end
      endcase
    end
  end

  assign tx_data  = tx_data_r;
  assign tx_valid = tx_valid_r;
  assign busy     = busy_r;
  assign seq      = seq_r;
  assign dropped  = dropped_r;

endmodule

// File: tb/tb_state_readout.sv
// Self-checking bench for state_readout: a frame-level model builds each
// expected frame as a byte queue when a start is accepted; a negedge
// process compares the DUT outputs against it every cycle.
module tb_state_readout;
  localparam int NB = 18;
  localparam int FL = NB + 3;

  logic         clk = 1'b0;
  logic         rst;
  logic [143:0] state;
  logic         start;
  logic         tx_ready;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         busy;
  logic [7:0]   seq;
  logic [15:0]  dropped;

  state_readout #(.HEADER(8'hA5), .NBYTES(NB)) dut (
    .clk(clk), .rst(rst), .state(state), .start(start),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .seq(seq), .dropped(dropped)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0]  exp_q[$];
  logic [7:0]  rx[$];
  int          busy_cnt = 0;
  logic [7:0]  m_seq  = 8'h00;
  logic [15:0] m_drop = 16'h0000;
  logic        m_busy = 1'b0;
  logic        mb_prev;
  logic [7:0]  cs_tmp;
  logic [143:0] s0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: a frame is the list of bytes it must put on the wire.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      m_seq  = 8'h00;
      m_drop = 16'h0000;
      m_busy = 1'b0;
    end else begin
      mb_prev = m_busy;
      if (m_busy && tx_ready) begin
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) begin
          m_busy = 1'b0;
          m_seq  = m_seq + 8'd1;
        end
      end
      if (start) begin
        if (!mb_prev) begin
          exp_q.push_back(8'hA5);
          exp_q.push_back(m_seq);
          cs_tmp = m_seq;
          for (int k = 0; k < NB; k++) begin
            exp_q.push_back(state[8*k +: 8]);
            cs_tmp = cs_tmp ^ state[8*k +: 8];
          end
          exp_q.push_back(cs_tmp);
          m_busy = 1'b1;
        end else if (m_drop != 16'hFFFF) begin
          m_drop = m_drop + 16'd1;
        end
      end
    end
  end

  // Per-cycle comparison against the model, plus a log of transferred bytes.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      chk("tx_valid", {31'd0, tx_valid}, {31'd0, m_busy});
      chk("busy", {31'd0, busy}, {31'd0, m_busy});
      chk("tx_data", {24'd0, tx_data}, {24'd0, (m_busy ? exp_q[0] : 8'h00)});
      chk("seq", {24'd0, seq}, {24'd0, m_seq});
      chk("dropped", {16'd0, dropped}, {16'd0, m_drop});
      if (busy) busy_cnt++;
      if (tx_valid && tx_ready) rx.push_back(tx_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 400) begin
      tick();
      n++;
    end
    if (busy) chk("wait_idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    state    = '0;
    start    = 1'b0;
    tx_ready = 1'b1;
    rst      = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_data", {24'd0, tx_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_seq", {24'd0, seq}, 32'd0);
    chk("rst_dropped", {16'd0, dropped}, 32'd0);
    rst = 1'b0;

    // All-zero state: A5, 00, 18 x 00, 00; busy for 21 cycles; seq then 01.
    rx.delete();
    busy_cnt = 0;
    pulse_start();
    chk("first_hdr_valid", {31'd0, tx_valid}, 32'd1);
    chk("first_hdr_data", {24'd0, tx_data}, 32'h0000_00A5);
    wait_idle();
    chk("zero_len", rx.size(), FL);
    chk("zero_hdr", {24'd0, rx[0]}, 32'h0000_00A5);
    chk("zero_seq", {24'd0, rx[1]}, 32'h0000_0000);
    chk("zero_b9", {24'd0, rx[11]}, 32'h0000_0000);
    chk("zero_csum", {24'd0, rx[20]}, 32'h0000_0000);
    chk("zero_busy_cycles", busy_cnt, 32'd21);
    chk("zero_seq_after", {24'd0, seq}, 32'h0000_0001);

    // Edge bytes: byte0=3C, byte17=81, checksum 00^3C^81=BD.
    do_reset();
    state = '0;
    state[7:0] = 8'h3C;
    state[143:136] = 8'h81;
    rx.delete();
    pulse_start();
    state = '0;
    wait_idle();
    chk("edge_b0", {24'd0, rx[2]}, 32'h0000_003C);
    chk("edge_b17", {24'd0, rx[19]}, 32'h0000_0081);
    chk("edge_csum", {24'd0, rx[20]}, 32'h0000_00BD);

    // Back-pressure at payload byte 4 while state toggles.
    s0 = 144'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210_5AC3;
    state = s0;
    rx.delete();
    pulse_start();
    repeat (6) tick();
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      state = ~state;
      tick();
      chk("hold_valid", {31'd0, tx_valid}, 32'd1);
      chk("hold_data", {24'd0, tx_data}, {24'd0, s0[39:32]});
    end
    tx_ready = 1'b1;
    wait_idle();
    chk("hold_len", rx.size(), FL);
    chk("hold_b4", {24'd0, rx[6]}, {24'd0, s0[39:32]});
    chk("hold_b17", {24'd0, rx[19]}, {24'd0, s0[143:136]});

    // Three mid-frame starts plus one on the CSUM transfer edge.
    do_reset();
    state = s0;
    rx.delete();
    pulse_start();
    for (int i = 0; i < FL; i++) begin
      start = (i == 3 || i == 7 || i == 11 || i == FL - 1);
      tick();
    end
    start = 1'b0;
    repeat (3) tick();
    chk("drop_count", {16'd0, dropped}, 32'd4);
    chk("drop_one_frame", rx.size(), FL);
    chk("drop_idle", {31'd0, busy}, 32'd0);

    // 257 frames: seq byte wraps 00..FF then 00.
    do_reset();
    for (int f = 0; f < 257; f++) begin
      state = {s0[135:0], 8'(f)};
      rx.delete();
      pulse_start();
      wait_idle();
      chk("wrap_len", rx.size(), FL);
      chk("wrap_seq", {24'd0, rx[1]}, {24'd0, 8'(f)});
    end

    // Reset at payload byte 10 aborts at once; next frame is complete, seq 00.
    state = s0;
    pulse_start();
    repeat (12) tick();
    #1;
    rst = 1'b1;
    #1;
    chk("abort_valid", {31'd0, tx_valid}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_data", {24'd0, tx_data}, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    rx.delete();
    pulse_start();
    wait_idle();
    chk("abort_len", rx.size(), FL);
    chk("abort_hdr", {24'd0, rx[0]}, 32'h0000_00A5);
    chk("abort_seq", {24'd0, rx[1]}, 32'h0000_0000);

    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
